// File: rtl/alu_pkg.sv
// alu_pkg: flag bit positions and widths shared by the ALU and its result FIFO
package alu_pkg;
  localparam int FLAG_W = 4;
  localparam int FLAG_ERR = 0;
  localparam int FLAG_NEG = 1;
  localparam int FLAG_POS = 2;
  localparam int FLAG_OVERFLOW = 3;
endpackage

// File: rtl/alu_sat_cnt.sv
// alu_sat_cnt: increment-only counter that holds at its maximum value
module alu_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (i_inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign o_cnt = cnt_q;
endmodule

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: first-word-fall-through FIFO for ALU results with drop pulse and error/overflow statistics
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  input  logic [WIDTH-1:0]         i_result,
  input  logic [FLAG_W-1:0]        i_flag,
  output logic                     o_ready,
  input  logic                     i_rd,
  output logic                     o_valid,
  output logic [WIDTH-1:0]         o_result,
  output logic [FLAG_W-1:0]        o_flag,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_drop,
  output logic [CNT_W-1:0]         o_err_cnt,
  output logic [CNT_W-1:0]         o_ovf_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = WIDTH + FLAG_W;
  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          drop_q, drop_d, push, pop;
  logic [EW-1:0] head;
  assign o_ready = count_q < CW'(DEPTH);
  assign o_valid = count_q != '0;
  assign push = i_valid && o_ready;
  assign pop = i_rd && o_valid;
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d = count_q + CW'(push) - CW'(pop);
    drop_d = i_valid && !o_ready;
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      drop_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      drop_q <= drop_d;
    end
  // storage is not reset; the i_rst gate keeps a reset edge from writing
  always_ff @(posedge i_clk)
    if (push && !i_rst) mem_q[wr_ptr_q] <= {i_result, i_flag};
  assign head = o_valid ? mem_q[rd_ptr_q] : '0;
  assign o_result = head[EW-1:FLAG_W];
  assign o_flag = head[FLAG_W-1:0];
  assign o_count = count_q;
  assign o_drop = drop_q;
  alu_sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
    .i_clk(i_clk), .i_rst(i_rst), .i_inc(push && i_flag[FLAG_ERR]), .o_cnt(o_err_cnt)
  );
  alu_sat_cnt #(.CNT_W(CNT_W)) u_ovf_cnt (
    .i_clk(i_clk), .i_rst(i_rst), .i_inc(push && i_flag[FLAG_OVERFLOW]), .o_cnt(o_ovf_cnt)
  );
endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: directed-vector bench for alu_result_fifo with default parameters
module tb_alu_result_fifo;
  logic       i_clk = 0, i_rst = 0, i_valid = 0, i_rd = 0;
  logic [3:0] i_result = 0, i_flag = 0;
  logic       o_ready, o_valid, o_drop;
  logic [3:0] o_result, o_flag;
  logic [2:0] o_count;
  logic [7:0] o_err_cnt, o_ovf_cnt;
  int checks = 0, errors = 0;

  alu_result_fifo dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_result(i_result), .i_flag(i_flag),
    .o_ready(o_ready), .i_rd(i_rd), .o_valid(o_valid), .o_result(o_result), .o_flag(o_flag),
    .o_count(o_count), .o_drop(o_drop), .o_err_cnt(o_err_cnt), .o_ovf_cnt(o_ovf_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_valid = 0; i_rd = 0;
    i_rst = 1;
    step();
    i_rst = 0;
  endtask

  task automatic push(input logic [3:0] r, input logic [3:0] f);
    i_valid = 1; i_result = r; i_flag = f;
    step();
    i_valid = 0;
  endtask

  task automatic test_reset();
    i_rst = 1;
    #2;
    checks++;
    if ({o_valid, o_ready, o_count, o_result, o_flag, o_drop, o_err_cnt, o_ovf_cnt} !== {1'b0, 1'b1, 3'd0, 4'd0, 4'd0, 1'b0, 8'd0, 8'd0}) begin
      errors++;
      $display("FAIL reset: valid=%b ready=%b count=%0d result=%h flag=%h drop=%b err=%0d ovf=%0d, want 0 1 0 0 0 0 0 0",
               o_valid, o_ready, o_count, o_result, o_flag, o_drop, o_err_cnt, o_ovf_cnt);
    end
    step();
    i_rst = 0;
  endtask

  task automatic test_single_push();
    push(4'b1101, 4'b0010);
    checks++;
    if ({o_valid, o_result, o_flag, o_count} !== {1'b1, 4'b1101, 4'b0010, 3'd1}) begin
      errors++;
      $display("FAIL single_push: valid=%b result=%b flag=%b count=%0d, want 1 1101 0010 1", o_valid, o_result, o_flag, o_count);
    end
    i_rd = 1; step(); i_rd = 0;
    checks++;
    if ({o_valid, o_count, o_result} !== {1'b0, 3'd0, 4'd0}) begin
      errors++;
      $display("FAIL single_pop: valid=%b count=%0d result=%h, want 0 0 0", o_valid, o_count, o_result);
    end
    i_rd = 1; step(); i_rd = 0;
    checks++;
    if ({o_valid, o_count, o_ready} !== {1'b0, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL empty_rd: valid=%b count=%0d ready=%b, want 0 0 1", o_valid, o_count, o_ready);
    end
  endtask

  task automatic test_fill_drop();
    do_reset();
    for (int k = 1; k <= 4; k++) push(4'(k), 4'b0100);
    checks++;
    if ({o_ready, o_count, o_drop, o_result} !== {1'b0, 3'd4, 1'b0, 4'd1}) begin
      errors++;
      $display("FAIL full: ready=%b count=%0d drop=%b head=%0d, want 0 4 0 1", o_ready, o_count, o_drop, o_result);
    end
    push(4'd9, 4'b0001);
    checks++;
    if ({o_drop, o_count, o_err_cnt} !== {1'b1, 3'd4, 8'd0}) begin
      errors++;
      $display("FAIL drop: drop=%b count=%0d err=%0d, want 1 4 0", o_drop, o_count, o_err_cnt);
    end
    step();
    checks++;
    if (o_drop !== 1'b0) begin
      errors++;
      $display("FAIL drop_pulse: drop=%b, want 0", o_drop);
    end
  endtask

  task automatic test_full_push_pop();
    i_valid = 1; i_rd = 1; i_result = 4'd7; i_flag = 4'b1000;
    step();
    i_valid = 0; i_rd = 0;
    checks++;
    if ({o_count, o_drop, o_result, o_ovf_cnt} !== {3'd3, 1'b1, 4'd2, 8'd0}) begin
      errors++;
      $display("FAIL full_push_pop: count=%0d drop=%b head=%0d ovf=%0d, want 3 1 2 0", o_count, o_drop, o_result, o_ovf_cnt);
    end
    for (int k = 2; k <= 4; k++) begin
      checks++;
      if (o_result !== 4'(k) || o_flag !== 4'b0100) begin
        errors++;
        $display("FAIL drain[%0d]: result=%0d flag=%b, want %0d 0100", k, o_result, o_flag, k);
      end
      i_rd = 1; step(); i_rd = 0;
    end
  endtask

  task automatic test_stats();
    do_reset();
    push(4'd3, 4'b0001);
    push(4'd5, 4'b0011);
    push(4'd6, 4'b1100);
    checks++;
    if ({o_err_cnt, o_ovf_cnt, o_count} !== {8'd2, 8'd1, 3'd3}) begin
      errors++;
      $display("FAIL stats_push: err=%0d ovf=%0d count=%0d, want 2 1 3", o_err_cnt, o_ovf_cnt, o_count);
    end
    i_rd = 1; repeat (3) step(); i_rd = 0;
    checks++;
    if ({o_err_cnt, o_ovf_cnt, o_valid, o_result, o_flag} !== {8'd2, 8'd1, 1'b0, 4'd0, 4'd0}) begin
      errors++;
      $display("FAIL stats_drain: err=%0d ovf=%0d valid=%b result=%h flag=%h, want 2 1 0 0 0",
               o_err_cnt, o_ovf_cnt, o_valid, o_result, o_flag);
    end
  endtask

  task automatic test_wrap_and_async_reset();
    do_reset();
    push(4'hA, 4'b0100);
    for (int k = 0; k < 6; k++) begin
      i_valid = 1; i_rd = 1; i_result = 4'(k); i_flag = 4'b0010;
      step();
      checks++;
      if ({o_count, o_result, o_flag} !== {3'd1, 4'(k), 4'b0010}) begin
        errors++;
        $display("FAIL wrap[%0d]: count=%0d result=%0d flag=%b, want 1 %0d 0010", k, o_count, o_result, o_flag, k);
      end
    end
    i_rd = 0;
    step();
    #2;
    i_rst = 1;
    #1;
    checks++;
    if ({o_valid, o_ready, o_count, o_result, o_flag, o_drop} !== {1'b0, 1'b1, 3'd0, 4'd0, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: valid=%b ready=%b count=%0d result=%h flag=%h drop=%b, want 0 1 0 0 0 0",
               o_valid, o_ready, o_count, o_result, o_flag, o_drop);
    end
    step();
    checks++;
    if (o_count !== 3'd0) begin
      errors++;
      $display("FAIL no_push_in_reset: count=%0d, want 0", o_count);
    end
    i_valid = 0; i_rst = 0;
  endtask

  task automatic test_saturation();
    do_reset();
    i_valid = 1; i_rd = 1; i_result = 4'd1; i_flag = 4'b0001;
    repeat (254) step();
    checks++;
    if (o_err_cnt !== 8'd254) begin
      errors++;
      $display("FAIL err_cnt_254: err=%0d, want 254", o_err_cnt);
    end
    repeat (46) step();
    i_valid = 0; i_rd = 0;
    checks++;
    if ({o_err_cnt, o_ovf_cnt} !== {8'd255, 8'd0}) begin
      errors++;
      $display("FAIL err_cnt_sat: err=%0d ovf=%0d, want 255 0", o_err_cnt, o_ovf_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill_drop();
    test_full_push_pop();
    test_stats();
    test_wrap_and_async_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
